// File: rtl/rcv_fsm_if.sv
// Handshake bundle between the serial receive controller, its bit-period
// counter and the byte consumer.
interface rcv_fsm_if #(
  parameter int DATA_BITS = 8
);
  logic                 serial_in;
  logic                 sample_strobe;
  logic                 data_read;
  logic                 timer_clear;
  logic                 timer_enable;
  logic [DATA_BITS-1:0] rx_data;
  logic                 data_ready;
  logic                 overrun_error;
  logic                 framing_error;
  logic                 busy;

  // slave: the receiver itself; master: whatever drives the line and reads bytes
  modport slave (
    input  serial_in, sample_strobe, data_read,
    output timer_clear, timer_enable, rx_data, data_ready,
           overrun_error, framing_error, busy
  );

  modport master (
    output serial_in, sample_strobe, data_read,
    input  timer_clear, timer_enable, rx_data, data_ready,
           overrun_error, framing_error, busy
  );
endinterface

// File: rtl/rcv_fsm.sv
// Serial receive controller: start detect, LSB-first deserialize on the
// bit-period strobe, stop-bit check and ready/read byte handshake.
module rcv_fsm #(
  parameter int DATA_BITS = 8
) (
  input logic         clk,
  input logic         rst,
  rcv_fsm_if.slave    bus
);
  localparam int CW = (DATA_BITS > 2) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    DATA,
    STOP,
    LOAD
  } state_t;

  state_t               state, next_state;
  logic                 q1, q2, q3;
  logic                 start_edge;
  logic [DATA_BITS-1:0] shift;
  logic [CW-1:0]        bit_cnt;
  logic                 stop_bit;
  logic [DATA_BITS-1:0] rx_data;
  logic                 data_ready, overrun_error, framing_error;
  logic                 tclr, ten;

  // q3 is only a history flop; the falling edge is seen one stage past the synchronizer
  assign start_edge = q3 & ~q2;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    tclr       = 1'b0;
    ten        = 1'b0;
    unique case (state)
      IDLE: begin
        tclr = 1'b1;
        if (start_edge) next_state = START_CHK;
      end
      START_CHK: begin
        ten = 1'b1;
        if (bus.sample_strobe) next_state = q2 ? IDLE : DATA;
      end
      DATA: begin
        ten = 1'b1;
        if (bus.sample_strobe && bit_cnt == LAST_BIT) next_state = STOP;
      end
      STOP: begin
        ten = 1'b1;
        if (bus.sample_strobe) next_state = LOAD;
      end
      LOAD: begin
        tclr       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q1       <= 1'b1;
      q2       <= 1'b1;
      q3       <= 1'b1;
      shift    <= '0;
      bit_cnt  <= '0;
      stop_bit <= 1'b0;
    end else begin
      q1 <= bus.serial_in;
      q2 <= q1;
      q3 <= q2;
      if (bus.sample_strobe) begin
        unique case (state)
          START_CHK: bit_cnt <= '0;
          DATA: begin
            shift   <= {q2, shift[DATA_BITS-1:1]};
            bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CW'(1);
          end
          STOP:    stop_bit <= q2;
          default: ;
        endcase
      end
    end
  end

  // A bad frame in LOAD leaves the handshake alone, including any read that cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else if (state == LOAD) begin
      if (stop_bit) begin
        rx_data       <= shift;
        data_ready    <= 1'b1;
        framing_error <= 1'b0;
        overrun_error <= data_ready & ~bus.data_read;
      end else begin
        framing_error <= 1'b1;
      end
    end else if (bus.data_read) begin
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
    end
  end

  assign bus.timer_clear   = tclr;
  assign bus.timer_enable  = ten;
  assign bus.rx_data       = rx_data;
  assign bus.data_ready    = data_ready;
  assign bus.overrun_error = overrun_error;
  assign bus.framing_error = framing_error;
  assign bus.busy          = (state != IDLE);
endmodule

// File: tb/tb_rcv_fsm.sv
// Scoreboard bench for rcv_fsm: frames driven bit by bit with a mid-bit
// strobe; expected handshake state comes from a frame-level model.
module tb_rcv_fsm;
  localparam int DB  = 8;
  localparam int P   = 8;          // cycles per serial bit
  localparam int STB = 2 + P / 2;  // strobe slot, offset for the 2-flop synchronizer

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rcv_fsm_if #(.DATA_BITS(DB)) bus ();
  rcv_fsm #(.DATA_BITS(DB)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [DB-1:0] rx;
    logic          rdy;
    logic          ovr;
    logic          fe;
    string         tag;
  } exp_t;

  exp_t q[$];
  int errs   = 0;
  int checks = 0;

  logic [DB-1:0] m_rx  = '0;
  logic          m_rdy = 1'b0;
  logic          m_ovr = 1'b0;
  logic          m_fe  = 1'b0;

  logic mon_en    = 1'b0;
  logic busy_prev = 1'b0;
  logic rd_q      = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.rx = m_rx; e.rdy = m_rdy; e.ovr = m_ovr; e.fe = m_fe; e.tag = tag;
    q.push_back(e);
  endtask

  // Monitor: an observable event is a busy fall (frame end, false start, abort) or a read.
  always @(posedge clk) rd_q <= bus.data_read;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("timer_exclusive", {31'd0, bus.timer_clear ^ bus.timer_enable}, 32'd1);
      if ((busy_prev && !bus.busy) || rd_q) begin
        if (q.size() == 0) begin
          chk("unexpected_event", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk({e.tag, ".rx_data"},       {24'd0, bus.rx_data},       {24'd0, e.rx});
          chk({e.tag, ".data_ready"},    {31'd0, bus.data_ready},    {31'd0, e.rdy});
          chk({e.tag, ".overrun_error"}, {31'd0, bus.overrun_error}, {31'd0, e.ovr});
          chk({e.tag, ".framing_error"}, {31'd0, bus.framing_error}, {31'd0, e.fe});
        end
      end
      busy_prev <= bus.busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    bus.data_read     = 1'b0;
    bus.sample_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      bus.serial_in     = 1'b1;
      bus.sample_strobe = ($urandom_range(3) == 0);  // strobes in IDLE must be ignored
    end
  endtask

  task automatic send_bit(input logic b);
    for (int c = 0; c < P; c++) begin
      tick();
      if (c == 0)   bus.serial_in = b;
      if (c == STB) bus.sample_strobe = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic rd_load,
                            input string tag, input bit chk_lat);
    if (stop) begin
      m_ovr = m_rdy && !rd_load;
      m_rx  = d;
      m_rdy = 1'b1;
      m_fe  = 1'b0;
    end else begin
      m_fe = 1'b1;
    end
    push(tag);
    for (int c = 0; c < P; c++) begin
      tick();
      if (c == 0) bus.serial_in = 1'b0;
      if (chk_lat && c == 2) chk({tag, ".busy_before_k2"}, {31'd0, bus.busy}, 32'd0);
      if (chk_lat && c == 3) begin
        chk({tag, ".busy_at_k2"},   {31'd0, bus.busy},         32'd1);
        chk({tag, ".enable_at_k2"}, {31'd0, bus.timer_enable}, 32'd1);
      end
      if (c == STB) bus.sample_strobe = 1'b1;
    end
    for (int i = 0; i < DB; i++) send_bit(d[i]);
    for (int c = 0; c < P; c++) begin
      tick();
      if (c == 0)       bus.serial_in = stop;
      if (c == STB)     bus.sample_strobe = 1'b1;
      if (c == STB + 1) bus.data_read = rd_load;  // lands on the LOAD cycle
    end
  endtask

  task automatic do_read(input string tag);
    m_rdy = 1'b0;
    m_ovr = 1'b0;
    push(tag);
    tick();
    bus.serial_in = 1'b1;
    bus.data_read = 1'b1;
  endtask

  task automatic false_start(input string tag);
    push(tag);
    for (int c = 0; c < P; c++) begin
      tick();
      if (c == 0)   bus.serial_in = 1'b0;
      if (c == 3)   bus.serial_in = 1'b1;
      if (c == STB) bus.sample_strobe = 1'b1;
    end
  endtask

  task automatic abort_frame(input logic [DB-1:0] d, input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    m_rx = '0; m_rdy = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    push("reset_mid");
    tick();
    rst           = 1'b1;
    bus.serial_in = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst               = 1'b1;
    bus.serial_in     = 1'b0;
    bus.sample_strobe = 1'b0;
    bus.data_read     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rx_data",       {24'd0, bus.rx_data},        32'd0);
    chk("reset.data_ready",    {31'd0, bus.data_ready},     32'd0);
    chk("reset.overrun_error", {31'd0, bus.overrun_error},  32'd0);
    chk("reset.framing_error", {31'd0, bus.framing_error},  32'd0);
    chk("reset.busy",          {31'd0, bus.busy},           32'd0);
    chk("reset.timer_clear",   {31'd0, bus.timer_clear},    32'd1);
    chk("reset.timer_enable",  {31'd0, bus.timer_enable},   32'd0);
    bus.serial_in = 1'b1;
    rst           = 1'b0;
    mon_en        = 1'b1;
    idle(4);
    chk("reset.no_start", {31'd0, bus.busy}, 32'd0);

    send_frame(8'hA5, 1'b1, 1'b0, "good_a5", 1'b1); idle(3);
    do_read("read_a5");                             idle(3);
    false_start("false_start");                     idle(3);
    send_frame(8'h3C, 1'b0, 1'b0, "fe_3c", 1'b0);   idle(3);
    send_frame(8'h01, 1'b1, 1'b0, "good_01", 1'b0); idle(3);
    do_read("read_01");                             idle(2);
    send_frame(8'h11, 1'b1, 1'b0, "ovr_11", 1'b0);  idle(2);
    send_frame(8'h22, 1'b1, 1'b0, "ovr_22", 1'b0);  idle(2);
    do_read("read_ovr");                            idle(2);
    send_frame(8'h33, 1'b1, 1'b0, "pre_33", 1'b0);  idle(2);
    send_frame(8'h44, 1'b1, 1'b1, "rd_at_load_44", 1'b0); idle(3);
    do_read("read_44");                             idle(2);
    abort_frame(8'h96, 4);                          idle(3);
    send_frame(8'h5A, 1'b1, 1'b0, "good_5a", 1'b1); idle(3);

    for (int n = 0; n < 40; n++) begin
      int r;
      r = $urandom_range(9);
      if (r == 0)      false_start("rnd_false");
      else if (r == 1) do_read("rnd_read");
      else send_frame(DB'($urandom), ($urandom_range(3) != 0), ($urandom_range(3) == 0),
                      "rnd_frame", ($urandom_range(3) == 0));
      idle($urandom_range(2, 6));
    end

    for (int w = 0; w < 200 && q.size() != 0; w++) @(posedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errs + 1, checks + 1);
    $fatal(1, "timeout");
  end
endmodule
